// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM frame receiver.
// Holds the code word width, the alternate-digit-inversion mask,
// the receiver state enum and a helper for sizing the slot index.
package pcm_pkg;

  localparam int PCM_CODE_W = 8;
  localparam logic [PCM_CODE_W-1:0] ADI_MASK = 8'h55;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } rx_state_t;

  function automatic int slot_w(input int slots);
    return $clog2(slots);
  endfunction

endpackage

// File: rtl/pcm_sipo8.sv
// Serial-in/parallel-out stage for one 8-bit A-law code word.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       zero the stored bits and the bit-in-slot counter
//   load        start a new word: din becomes bit 7, counter goes to 1
//   shift       append din (MSB first) and advance the bit-in-slot counter
//   din         serial line bit
//   word        the word completed by the current bit: stored bits + din
//   bit_cnt     bit-in-slot position of the bit currently on din
module pcm_sipo8 import pcm_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  din,
  output logic [PCM_CODE_W-1:0] word,
  output logic [2:0]            bit_cnt
);

  // Only the first seven bits of a word need storing: the eighth (LSB)
  // is taken straight from the line in the cycle the word completes, so
  // the code register in the parent can capture it without extra delay.
  logic [PCM_CODE_W-2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= {{(PCM_CODE_W-2){1'b0}}, din};
      bit_cnt <= 3'd1;
    end else if (shift) begin
      sr      <= {sr[PCM_CODE_W-3:0], din};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign word = {sr, din};

endmodule

// File: rtl/pcm_frame_rx.sv
// Serial TDM PCM receiver: deserialises 8-bit A-law words MSB first,
// optionally removes alternate-digit inversion, tags each word with its
// timeslot and keeps frame alignment with a flywheel on the frame sync.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bit_en      one-clk strobe per line bit; sdata/fsync sampled only then
//   sdata       serial PCM data, MSB of each slot first
//   fsync       frame sync, high with bit 7 of slot 0
//   code        received code word (ADI removed when ADI_EN=1)
//   slot        timeslot index of code
//   code_valid  one-clk pulse when code/slot are fresh
//   in_sync     high while aligned to the frame
//   frame_err   one-clk pulse on a misplaced or missing frame sync
module pcm_frame_rx import pcm_pkg::*; #(
  parameter int SLOTS    = 32,
  parameter int MISS_MAX = 3,
  parameter bit ADI_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_en,
  input  logic                       sdata,
  input  logic                       fsync,
  output logic [PCM_CODE_W-1:0]      code,
  output logic [slot_w(SLOTS)-1:0]   slot,
  output logic                       code_valid,
  output logic                       in_sync,
  output logic                       frame_err
);

  localparam int                    SW        = slot_w(SLOTS);
  localparam logic [SW-1:0]         LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [3:0]            MISS_LAST = 4'(MISS_MAX - 1);
  localparam logic [PCM_CODE_W-1:0] ADI_XOR   = ADI_EN ? ADI_MASK : '0;

  rx_state_t             state;
  logic [SW-1:0]         slot_cnt;
  logic [3:0]            miss_cnt;
  logic [2:0]            bit_cnt;
  logic [PCM_CODE_W-1:0] word;

  logic at_fbit0;
  logic sync_start;
  logic misplaced;
  logic missing;
  logic lost;
  logic accept;
  logic word_done;

  // The frame bit position is {slot_cnt, bit_cnt}; the low three bits live
  // in the SIPO so the word and its bit position advance together.
  assign at_fbit0   = (slot_cnt == '0) && (bit_cnt == 3'd0);
  assign sync_start = bit_en && (state == HUNT) && fsync;
  assign misplaced  = bit_en && (state == SYNC) && fsync && !at_fbit0;
  assign missing    = bit_en && (state == SYNC) && !fsync && at_fbit0;
  // The miss that reaches MISS_MAX drops alignment; that bit is not kept.
  assign lost       = missing && (miss_cnt == MISS_LAST);
  // A missing sync below the limit still flywheels and keeps the bit.
  assign accept     = bit_en && (state == SYNC) && !misplaced && !lost;
  assign word_done  = accept && (bit_cnt == 3'd7);

  pcm_sipo8 u_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (lost),
    .load    (sync_start || misplaced),
    .shift   (accept),
    .din     (sdata),
    .word    (word),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot_cnt   <= '0;
      miss_cnt   <= '0;
      code       <= '0;
      slot       <= '0;
      code_valid <= 1'b0;
      in_sync    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (fsync) begin
              state    <= SYNC;
              in_sync  <= 1'b1;
              slot_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          SYNC: begin
            if (misplaced) begin
              // Realign on this bit as bit 7 of slot 0; partial word dropped.
              frame_err <= 1'b1;
              slot_cnt  <= '0;
              miss_cnt  <= '0;
            end else if (lost) begin
              frame_err <= 1'b1;
              state     <= HUNT;
              in_sync   <= 1'b0;
              slot_cnt  <= '0;
              miss_cnt  <= '0;
            end else begin
              if (missing) begin
                frame_err <= 1'b1;
                miss_cnt  <= miss_cnt + 4'd1;
              end else if (at_fbit0) begin
                miss_cnt  <= '0;
              end
              if (word_done) begin
                code       <= word ^ ADI_XOR;
                slot       <= slot_cnt;
                code_valid <= 1'b1;
                slot_cnt   <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + SW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_rx.sv
// Self-checking bench for pcm_frame_rx. A bit-level reference model built
// from frame arithmetic (integer frame position, integer word accumulator)
// predicts every output after every clock.
module tb_pcm_frame_rx;

  localparam int SLOTS    = 32;
  localparam int MISS_MAX = 3;
  localparam bit ADI_EN   = 1'b1;
  localparam int SW       = $clog2(SLOTS);
  localparam int FBITS    = SLOTS * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_en = 1'b0;
  logic          sdata = 1'b0;
  logic          fsync = 1'b0;
  logic [7:0]    code;
  logic [SW-1:0] slot;
  logic          code_valid;
  logic          in_sync;
  logic          frame_err;

  always #5 clk = ~clk;

  pcm_frame_rx #(
    .SLOTS    (SLOTS),
    .MISS_MAX (MISS_MAX),
    .ADI_EN   (ADI_EN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .sdata      (sdata),
    .fsync      (fsync),
    .code       (code),
    .slot       (slot),
    .code_valid (code_valid),
    .in_sync    (in_sync),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int err_seen = 0;

  // Reference model state
  bit m_sync;
  int m_fbit;
  int m_word;
  int m_miss;
  int e_code;
  int e_slot;
  bit e_valid;
  bit e_err;

  int   line_pos;
  logic fs_r;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_sync  = 1'b0;
    m_fbit  = 0;
    m_word  = 0;
    m_miss  = 0;
    e_code  = 0;
    e_slot  = 0;
    e_valid = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic modelStep(input logic sd, input logic fs);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!m_sync) begin
      if (fs) begin
        m_sync = 1'b1;
        m_fbit = 1;
        m_word = int'(sd);
        m_miss = 0;
      end
    end else if (fs && m_fbit != 0) begin
      e_err  = 1'b1;
      m_fbit = 1;
      m_word = int'(sd);
      m_miss = 0;
    end else begin
      if (m_fbit == 0) begin
        if (fs) m_miss = 0;
        else begin
          e_err  = 1'b1;
          m_miss = m_miss + 1;
        end
      end
      if (m_miss == MISS_MAX) begin
        m_sync = 1'b0;
        m_miss = 0;
        m_fbit = 0;
      end else begin
        if (m_fbit % 8 == 0) m_word = int'(sd);
        else m_word = m_word * 2 + int'(sd);
        if (m_fbit % 8 == 7) begin
          e_valid = 1'b1;
          e_code  = ADI_EN ? (m_word ^ 'h55) : m_word;
          e_slot  = m_fbit / 8;
        end
        m_fbit = (m_fbit + 1) % FBITS;
      end
    end
  endtask

  task automatic compareAll(input string phase);
    checkOutput({phase, "_code_valid"}, 32'(code_valid), 32'(e_valid));
    checkOutput({phase, "_frame_err"}, 32'(frame_err), 32'(e_err));
    checkOutput({phase, "_in_sync"}, 32'(in_sync), 32'(m_sync));
    checkOutput({phase, "_code"}, 32'(code), 32'(e_code));
    checkOutput({phase, "_slot"}, 32'(slot), 32'(e_slot));
    if (code_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
  endtask

  task automatic applyStimulus(input logic en, input logic sd, input logic fs);
    bit_en = en;
    sdata  = sd;
    fsync  = fs;
    @(posedge clk);
    #1;
    if (en) modelStep(sd, fs);
    else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
    end
    compareAll("cyc");
  endtask

  task automatic sendBit(input logic sd, input logic fs, input int gap);
    applyStimulus(1'b1, sd, fs);
    for (int g = 0; g < gap; g++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic sendWord(input logic [7:0] w, input logic fs_first, input int gap);
    for (int i = 7; i >= 0; i--)
      sendBit(w[i], (i == 7) ? fs_first : 1'b0, gap);
  endtask

  initial begin
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compareAll("reset");
    rst_n = 1'b1;

    // Single word 0xD5 through ADI -> 0x80 in slot 0
    sendWord(8'hD5, 1'b1, 0);
    checkOutput("t1_code_80", 32'(code), 32'h80);
    checkOutput("t1_slot_0", 32'(slot), 32'd0);
    checkOutput("t1_valid", 32'(code_valid), 32'd1);
    checkOutput("t1_in_sync", 32'(in_sync), 32'd1);

    // Finish the frame, then three full back-to-back frames, slot n -> code n
    for (int s = 1; s < SLOTS; s++) sendWord(8'(s) ^ 8'h55, 1'b0, 0);
    valid_seen = 0;
    err_seen = 0;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < SLOTS; s++)
        sendWord(8'(s) ^ 8'h55, (s == 0), 0);
    checkOutput("t2_valid_count", 32'(valid_seen), 32'd96);
    checkOutput("t2_err_count", 32'(err_seen), 32'd0);
    checkOutput("t2_last_slot", 32'(slot), 32'(SLOTS - 1));
    checkOutput("t2_last_code", 32'(code), 32'(SLOTS - 1));

    // Withhold fsync for three frames
    valid_seen = 0;
    err_seen = 0;
    for (int n = 0; n < 3 * FBITS + 20; n++) sendBit(1'($urandom_range(0, 1)), 1'b0, 0);
    checkOutput("t3_valid_count", 32'(valid_seen), 32'd64);
    checkOutput("t3_err_count", 32'(err_seen), 32'd3);
    checkOutput("t3_in_sync", 32'(in_sync), 32'd0);

    // Resync, then misplaced fsync at fbit 13
    sendWord(8'($urandom_range(0, 255)), 1'b1, 0);
    checkOutput("t4_resync", 32'(in_sync), 32'd1);
    for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)), 1'b0, 0);
    valid_seen = 0;
    sendBit(1'b1, 1'b1, 0);
    checkOutput("t4_frame_err", 32'(frame_err), 32'd1);
    for (int i = 0; i < 7; i++) sendBit(1'($urandom_range(0, 1)), 1'b0, 0);
    checkOutput("t4_valid_count", 32'(valid_seen), 32'd1);
    checkOutput("t4_slot_0", 32'(slot), 32'd0);

    // bit_en every 4th clk, reset in the middle of slot 5
    for (int s = 0; s < SLOTS; s++) sendWord(8'($urandom_range(0, 255)), 1'b0, 0);
    valid_seen = 0;
    sendWord(8'($urandom_range(0, 255)), 1'b1, 3);
    for (int s = 1; s < 5; s++) sendWord(8'($urandom_range(0, 255)), 1'b0, 3);
    for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)), 1'b0, 3);
    checkOutput("t5_valid_count", 32'(valid_seen), 32'd5);
    checkOutput("t5_pre_in_sync", 32'(in_sync), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t5_rst_code", 32'(code), 32'd0);
    checkOutput("t5_rst_slot", 32'(slot), 32'd0);
    checkOutput("t5_rst_valid", 32'(code_valid), 32'd0);
    checkOutput("t5_rst_in_sync", 32'(in_sync), 32'd0);
    checkOutput("t5_rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) sendBit(1'($urandom_range(0, 1)), 1'b0, 3);
    checkOutput("t5_hunt", 32'(in_sync), 32'd0);
    sendWord(8'($urandom_range(0, 255)), 1'b1, 3);
    checkOutput("t5_resync_slot0", 32'(slot), 32'd0);
    sendWord(8'($urandom_range(0, 255)), 1'b0, 3);
    sendWord(8'($urandom_range(0, 255)), 1'b0, 3);
    checkOutput("t5_slot_2", 32'(slot), 32'd2);

    // Random line: occasional dropped and spurious frame syncs, random gaps
    line_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      if (line_pos == 0) fs_r = ($urandom_range(0, 7) != 0);
      else fs_r = ($urandom_range(0, 599) == 0);
      sendBit(1'($urandom_range(0, 1)), fs_r, $urandom_range(0, 2));
      line_pos = (line_pos + 1) % FBITS;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
